mem_access_controller: RTL and testbench

- Sequences data-memory accesses in the MEM stage of the 5-stage MIPS pipeline when memory takes multiple cycles.
- Counts fixed wait states for each load or store.
- While waiting, it freezes PC, IF/ID, ID/EX and EX/MEM, and injects a bubble into the MEM/WB register so the register file is not written twice.
- Sits beside the MEM/WB pipeline register; drives its bubble control and the hazard/stall network.

---
 rtl/mem_access_controller.sv | 172 +++++++++++++++++
 tb/tb_mem_access_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_controller.sv
// mem_access_controller
// Sequences multi-cycle data-memory accesses in the MEM stage of the 5-stage
// MIPS pipeline. For each load or store it inserts MEM_LATENCY wait cycles.
// During those cycles it freezes PC, IF/ID, ID/EX and EX/MEM, and it injects
// a bubble into MEM/WB.
//
// Optional build macro: MEM_ACCESS_PERF_EN adds saturating performance counters.
//
// Ports:
//   clk           pipeline clock, rising edge
//   rst           asynchronous active-high reset
//   mem_read_in   EX/MEM MemRead of the instruction in MEM
//   mem_write_in  EX/MEM MemWrite of the instruction in MEM
//   mem_req       data-memory access enable
//   mem_we        data-memory write enable (valid while mem_req=1)
//   stall         hold PC, IF/ID, ID/EX, EX/MEM
//   wb_bubble     force RegWrite/MemToReg low into MEM/WB
//   busy          controller in ACCESS or DONE
//   conflict_err  sticky: read and write requested together
//   stall_cycles  (MEM_ACCESS_PERF_EN) edges with stall=1
//   access_count  (MEM_ACCESS_PERF_EN) completed accesses
module mem_access_controller #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic        stall,
    output logic        wb_bubble,
    output logic        busy,
    output logic        conflict_err
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] access_count
`endif
);

    // Elaboration-time range check on the wait counter
    if (MEM_LATENCY >= (2 ** CNT_W)) begin : g_bad_cnt_w
        $error("mem_access_controller: MEM_LATENCY must be < 2**CNT_W");
    end

    // The IDLE cycle that first sees the request is the first wait cycle.
    // The ACCESS state therefore covers the remaining MEM_LATENCY-1 cycles.
    // cnt counts ACCESS cycles left after the current one.
    localparam int unsigned CNT_LOAD_I = (MEM_LATENCY >= 2) ? (MEM_LATENCY - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_LOAD_I);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             conflict_q;
    logic             req, wr;

    assign req          = mem_read_in | mem_write_in;
    assign wr           = mem_write_in;
    assign conflict_err = conflict_q;

    // State, wait counter and sticky conflict flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_q | (mem_read_in & mem_write_in);
        end
    end

    // Next-state and combinational outputs; the stall appears in the request cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        stall     = 1'b0;
        wb_bubble = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                mem_req = req;
                mem_we  = wr;
                if (req && (MEM_LATENCY > 0)) begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                    if (MEM_LATENCY == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ACCESS: begin
                // EX/MEM is frozen, so mem_write_in is stable here
                mem_req   = 1'b1;
                mem_we    = mem_write_in;
                stall     = 1'b1;
                wb_bubble = 1'b1;
                busy      = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // A request still held here belongs to the finishing instruction
                mem_req = 1'b1;
                mem_we  = wr;
                busy    = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are quiet for the whole time reset is held
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            stall     = 1'b0;
            wb_bubble = 1'b0;
            busy      = 1'b0;
        end
    end

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] access_count_q;
    logic        access_evt;

    // An access completes in DONE, or in IDLE when memory is single-cycle
    assign access_evt = (state_q == DONE) ||
                        ((state_q == IDLE) && req && (MEM_LATENCY == 0));

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            access_count_q <= '0;
        end else begin
            if (stall && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (access_evt && (access_count_q != '1)) begin
                access_count_q <= access_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign access_count = access_count_q;
`endif

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller with latency 2, 0 and 3 instances.
module tb_mem_access_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Latency-2 instance
    logic rst2 = 1'b1, rd2 = 1'b0, wr2 = 1'b0;
    logic req2, we2, st2, bub2, busy2, cerr2;
    // Latency-0 instance
    logic rst0 = 1'b1, rd0 = 1'b0, wr0 = 1'b0;
    logic req0, we0, st0, bub0, busy0, cerr0;
    // Latency-3 instance
    logic rst3 = 1'b1, rd3 = 1'b0, wr3 = 1'b0;
    logic req3, we3, st3, bub3, busy3, cerr3;

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] sc2, ac2, sc0, ac0, sc3, ac3;
`endif

    mem_access_controller #(.MEM_LATENCY(2), .CNT_W(4)) u_l2 (
        .clk(clk), .rst(rst2), .mem_read_in(rd2), .mem_write_in(wr2),
        .mem_req(req2), .mem_we(we2), .stall(st2), .wb_bubble(bub2),
        .busy(busy2), .conflict_err(cerr2)
`ifdef MEM_ACCESS_PERF_EN
        , .stall_cycles(sc2), .access_count(ac2)
`endif
    );

    mem_access_controller #(.MEM_LATENCY(0), .CNT_W(4)) u_l0 (
        .clk(clk), .rst(rst0), .mem_read_in(rd0), .mem_write_in(wr0),
        .mem_req(req0), .mem_we(we0), .stall(st0), .wb_bubble(bub0),
        .busy(busy0), .conflict_err(cerr0)
`ifdef MEM_ACCESS_PERF_EN
        , .stall_cycles(sc0), .access_count(ac0)
`endif
    );

    mem_access_controller #(.MEM_LATENCY(3), .CNT_W(4)) u_l3 (
        .clk(clk), .rst(rst3), .mem_read_in(rd3), .mem_write_in(wr3),
        .mem_req(req3), .mem_we(we3), .stall(st3), .wb_bubble(bub3),
        .busy(busy3), .conflict_err(cerr3)
`ifdef MEM_ACCESS_PERF_EN
        , .stall_cycles(sc3), .access_count(ac3)
`endif
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One cycle of the latency-2 instance: inputs, then expected outputs
    typedef struct packed {
        logic rst;
        logic rd;
        logic wr;
        logic req;
        logic we;
        logic st;
        logic bub;
        logic busy;
        logic cerr;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] exp_sc;
    logic [31:0] exp_ac;
`endif

    initial begin
        //            rst rd wr _ req we st bub busy cerr
        vecs[0]  = 9'b1_1_1_0_0_0_0_0_0;  // reset masks inputs
        vecs[1]  = 9'b0_1_0_1_0_1_1_0_0;  // load seen in IDLE: stall now
        vecs[2]  = 9'b0_1_0_1_0_1_1_1_0;  // ACCESS
        vecs[3]  = 9'b0_1_0_1_0_0_0_1_0;  // DONE, held req ignored
        vecs[4]  = 9'b0_0_0_0_0_0_0_0_0;  // back in IDLE
        vecs[5]  = 9'b0_1_0_1_0_1_1_0_0;  // back-to-back load 1
        vecs[6]  = 9'b0_1_0_1_0_1_1_1_0;
        vecs[7]  = 9'b0_1_0_1_0_0_0_1_0;
        vecs[8]  = 9'b0_1_0_1_0_1_1_0_0;  // load 2 stalls in IDLE
        vecs[9]  = 9'b0_1_0_1_0_1_1_1_0;
        vecs[10] = 9'b0_1_0_1_0_0_0_1_0;
        vecs[11] = 9'b0_0_1_1_1_1_1_0_0;  // store
        vecs[12] = 9'b0_0_0_1_0_1_1_1_0;  // request dropped in ACCESS
        vecs[13] = 9'b0_0_0_1_0_0_0_1_0;  // still completes
        vecs[14] = 9'b0_0_0_0_0_0_0_0_0;
        vecs[15] = 9'b0_1_1_1_1_1_1_0_0;  // conflict: write wins
        vecs[16] = 9'b0_0_0_1_0_1_1_1_1;  // sticky flag from that edge
        vecs[17] = 9'b0_0_0_1_0_0_0_1_1;
        vecs[18] = 9'b0_0_0_0_0_0_0_0_1;
        vecs[19] = 9'b1_0_0_0_0_0_0_0_0;  // reset clears flag
        vecs[20] = 9'b0_0_0_0_0_0_0_0_0;

`ifdef MEM_ACCESS_PERF_EN
        exp_sc = '0;
        exp_ac = '0;
`endif

        // Latency 2: table-driven sequence
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst2 = vecs[i].rst;
            rd2  = vecs[i].rd;
            wr2  = vecs[i].wr;
            #1;
            chk1($sformatf("l2 v%0d mem_req", i), req2, vecs[i].req);
            chk1($sformatf("l2 v%0d mem_we", i), we2, vecs[i].we);
            chk1($sformatf("l2 v%0d stall", i), st2, vecs[i].st);
            chk1($sformatf("l2 v%0d wb_bubble", i), bub2, vecs[i].bub);
            chk1($sformatf("l2 v%0d busy", i), busy2, vecs[i].busy);
            chk1($sformatf("l2 v%0d conflict_err", i), cerr2, vecs[i].cerr);
`ifdef MEM_ACCESS_PERF_EN
            if (vecs[i].rst) begin
                exp_sc = '0;
                exp_ac = '0;
            end
            chk32($sformatf("l2 v%0d stall_cycles", i), sc2, exp_sc);
            chk32($sformatf("l2 v%0d access_count", i), ac2, exp_ac);
            if (!vecs[i].rst) begin
                exp_sc = exp_sc + 32'(vecs[i].st);
                exp_ac = exp_ac + 32'(vecs[i].busy & ~vecs[i].st);
            end
`endif
        end

`ifdef MEM_ACCESS_PERF_EN
        // Latency 2: three loads give 6 stall cycles and 3 accesses
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        @(negedge clk);
        rst2 = 1'b0;
        rd2  = 1'b1;
        repeat (9) @(negedge clk);
        rd2 = 1'b0;
        #1;
        chk32("l2 perf stall_cycles", sc2, 32'd6);
        chk32("l2 perf access_count", ac2, 32'd3);
`endif

        // Latency 0: reset masks request, then three single-cycle stores
        @(negedge clk);
        wr0 = 1'b1;
        #1;
        chk1("l0 reset mem_req", req0, 1'b0);
        chk1("l0 reset mem_we", we0, 1'b0);
        @(negedge clk);
        rst0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk1($sformatf("l0 c%0d stall", k), st0, 1'b0);
            chk1($sformatf("l0 c%0d wb_bubble", k), bub0, 1'b0);
            chk1($sformatf("l0 c%0d mem_req", k), req0, 1'b1);
            chk1($sformatf("l0 c%0d mem_we", k), we0, 1'b1);
            chk1($sformatf("l0 c%0d busy", k), busy0, 1'b0);
        end
        @(negedge clk);
        wr0 = 1'b0;
        #1;
        chk1("l0 after mem_req", req0, 1'b0);
`ifdef MEM_ACCESS_PERF_EN
        chk32("l0 access_count", ac0, 32'd3);
        chk32("l0 stall_cycles", sc0, 32'd0);
`endif

        // Latency 3: store aborted by asynchronous reset mid-access
        @(negedge clk);
        rst3 = 1'b0;
        @(negedge clk);
        wr3 = 1'b1;
        #1;
        chk1("l3 c0 stall", st3, 1'b1);
        chk1("l3 c0 mem_req", req3, 1'b1);
        chk1("l3 c0 mem_we", we3, 1'b1);
        chk1("l3 c0 busy", busy3, 1'b0);
        @(negedge clk);
        #1;
        chk1("l3 c1 stall", st3, 1'b1);
        chk1("l3 c1 busy", busy3, 1'b1);
        #2;
        rst3 = 1'b1;
        #1;
        chk1("l3 rst stall", st3, 1'b0);
        chk1("l3 rst mem_req", req3, 1'b0);
        chk1("l3 rst busy", busy3, 1'b0);
        chk1("l3 rst wb_bubble", bub3, 1'b0);
        @(negedge clk);
        rst3 = 1'b0;
        wr3  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk1($sformatf("l3 post%0d stall", k), st3, 1'b0);
            chk1($sformatf("l3 post%0d mem_req", k), req3, 1'b0);
            chk1($sformatf("l3 post%0d busy", k), busy3, 1'b0);
        end

        // Latency 3: full store stalls exactly three cycles
        begin
            logic [3:0] exp_st;
            logic [3:0] exp_busy;
            exp_st   = 4'b0111;  // bit k = cycle k
            exp_busy = 4'b1110;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                wr3 = 1'b1;
                #1;
                chk1($sformatf("l3 full c%0d stall", k), st3, exp_st[k]);
                chk1($sformatf("l3 full c%0d busy", k), busy3, exp_busy[k]);
                chk1($sformatf("l3 full c%0d mem_req", k), req3, 1'b1);
            end
            @(negedge clk);
            wr3 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
